// File: rtl/cnt_pkg.sv
// cnt_pkg -- shared constants for the up/down counter slice.
`default_nettype none

package cnt_pkg;

   localparam int CNT_WIDTH_MIN    = 2;
   localparam int CNT_WIDTH_MAX    = 32;
   localparam int CNT_PRESCALE_MIN = 1;
   localparam int CNT_PRESCALE_MAX = 256;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   localparam logic MODE_WRAP = 1'b0;

   // A 1-bit prescaler is kept for PRESCALE=1 so the register never has zero width.
   function automatic int prescale_width(input int p);
      return (p > 1) ? $clog2(p) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// tick_prescaler -- divides enabled cycles by PRESCALE, pulsing tick on the last one.
`default_nettype none

module tick_prescaler
   import cnt_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int              c_PW   = prescale_width(PRESCALE);
   localparam logic [c_PW-1:0] c_LAST = c_PW'(PRESCALE - 1);

   logic [c_PW-1:0] r_cnt;
   logic            w_last;

   assign w_last = (r_cnt == c_LAST);
   assign tick   = en & w_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_last ? '0 : r_cnt + c_PW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/mod_updown_counter.sv
// mod_updown_counter -- prescaled up/down counter over 0..max_val with wrap or saturate.
`default_nettype none

module mod_updown_counter
   import cnt_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             sat
);

   logic             w_tick;
   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic             r_sat;
   logic             r_sat_up;

   logic             w_at_top;
   logic             w_at_zero;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_wrap_nxt;
   logic             w_sat_nxt;
   logic             w_sat_up_nxt;

   // A load also clears the prescaler so the next step needs a full PRESCALE run.
   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (load),
      .tick  (w_tick)
   );

   // ">=" rather than "==" lets a count stranded above a lowered max_val re-enter range.
   assign w_at_top  = (r_count >= max_val);
   assign w_at_zero = (r_count == '0);
   assign tc        = (up_dn == DIR_UP) ? w_at_top : w_at_zero;

   always_comb begin
      w_count_nxt  = r_count;
      w_wrap_nxt   = 1'b0;
      w_sat_nxt    = r_sat;
      w_sat_up_nxt = r_sat_up;
      if (load) begin
         w_count_nxt = (load_val > max_val) ? max_val : load_val;
         w_sat_nxt   = 1'b0;
      end else if (w_tick) begin
         if (up_dn == DIR_UP) begin
            if (!w_at_top) begin
               w_count_nxt = r_count + WIDTH'(1);
               w_sat_nxt   = 1'b0;
            end else if (sat_mode == MODE_SAT) begin
               w_count_nxt  = max_val;
               w_sat_nxt    = 1'b1;
               w_sat_up_nxt = DIR_UP;
            end else begin
               w_count_nxt = '0;
               w_wrap_nxt  = 1'b1;
               w_sat_nxt   = 1'b0;
            end
         end else begin
            if (!w_at_zero) begin
               w_count_nxt = r_count - WIDTH'(1);
               w_sat_nxt   = 1'b0;
            end else if (sat_mode == MODE_SAT) begin
               w_sat_nxt    = 1'b1;
               w_sat_up_nxt = DIR_DOWN;
            end else begin
               w_count_nxt = max_val;
               w_wrap_nxt  = 1'b1;
               w_sat_nxt   = 1'b0;
            end
         end
      end else if (r_sat && (up_dn != r_sat_up)) begin
         // Turning away from the bound we saturated against releases the flag.
         w_sat_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count  <= '0;
         r_wrap   <= 1'b0;
         r_sat    <= 1'b0;
         r_sat_up <= DIR_UP;
      end else begin
         r_count  <= w_count_nxt;
         r_wrap   <= w_wrap_nxt;
         r_sat    <= w_sat_nxt;
         r_sat_up <= w_sat_up_nxt;
      end
   end

   assign count = r_count;
   assign wrap  = r_wrap;
   assign sat   = r_sat;

endmodule

`default_nettype wire

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: count width in bits, legal range 2..32.
REQ-002 Parameter PRESCALE, default 1: enabled cycles per count step, legal range 1..256.
REQ-003 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous, active-high.
REQ-005 Port en, input, 1: count enable; feeds the prescaler.
REQ-006 Port up_dn, input, 1: direction; 1 counts up, 0 counts down.
REQ-007 Port sat_mode, input, 1: boundary behaviour; 1 saturates, 0 wraps.
REQ-008 Port load, input, 1: synchronous load strobe.
REQ-009 Port load_val, input, WIDTH: value to load.
REQ-010 Port max_val, input, WIDTH: inclusive upper bound; the count range is 0..max_val.
REQ-011 Port count, output, WIDTH: registered count value.
REQ-012 Port tc, output, 1: terminal count (combinational).
REQ-013 Port wrap, output, 1: registered one-cycle pulse that flags a wrap.
REQ-014 Port sat, output, 1: registered level that flags the count is held at a bound in saturate mode.

Function
REQ-015 Priority per edge SHALL be: reset, then load, then step.
REQ-016 On load, count SHALL be set to min(load_val, max_val); the prescaler SHALL clear to 0; wrap SHALL be 0 and sat SHALL be 0 on the next cycle.
REQ-017 The prescaler SHALL increment on each en=1 cycle; a tick SHALL occur when it equals PRESCALE-1 and en=1, and the prescaler SHALL then return to 0.
REQ-018 With PRESCALE=1, every en=1 cycle SHALL be a tick; en=0 SHALL freeze both the prescaler and count.
REQ-019 On a tick with up_dn=1 and count<max_val, count SHALL become count+1.
REQ-020 On a tick with up_dn=0 and count>0, count SHALL become count-1.
REQ-021 On a tick with up_dn=1 and count>=max_val: if sat_mode=0, count SHALL become 0 and wrap SHALL be 1 next cycle; if sat_mode=1, count SHALL become max_val and sat SHALL be 1.
REQ-022 On a tick with up_dn=0 and count=0: if sat_mode=0, count SHALL become max_val and wrap SHALL be 1 next cycle; if sat_mode=1, count SHALL stay 0 and sat SHALL be 1.
REQ-023 REQ-021 covers count>max_val (after max_val is lowered), so count SHALL re-enter range on the next tick.
REQ-024 wrap SHALL be 0 in every cycle not directly following a wrapping tick.
REQ-025 sat SHALL clear on any tick that moves count, on load, and on a direction change away from the bound.
REQ-026 tc SHALL be 1 when (up_dn=1 and count>=max_val) or (up_dn=0 and count=0), independent of en.
REQ-027 With max_val=0, count SHALL stay 0; a tick SHALL pulse wrap (sat_mode=0) or set sat (sat_mode=1).
REQ-028 All arithmetic SHALL be modulo 2^WIDTH with no carry out; no internal overflow SHALL occur at max_val=2^WIDTH-1.

Reset
REQ-029 Asserting reset SHALL immediately force count=0, prescaler=0, wrap=0 and sat=0, regardless of clk.
REQ-030 Reset asserted mid-prescale SHALL discard any partial prescale progress; the first tick after release SHALL need a full PRESCALE enabled cycles.
REQ-031 The first edge after reset deassertion SHALL obey REQ-015 normally.

Structure
REQ-032 Shared package cnt_pkg SHALL hold the parameter legal-range constants and the direction/mode encodings.
REQ-033 The prescaler SHALL be the sub-module tick_prescaler, with inputs clk, reset, en and clr, and output tick.
REQ-034 The top level SHALL contain only the count register, the next-count logic and the flag registers.

Verification
REQ-035 Scenario 1 (WIDTH=4, PRESCALE=1, max_val=9, sat_mode=0, up, en=1 for 12 cycles): count runs 0..9, 0, 1; wrap is high one cycle after 9->0.
REQ-036 Scenario 2 (sat_mode=1, down from 2, 4 ticks): count runs 2, 1, 0, 0, 0; sat=1 from the first stay at 0; tc=1 while count=0.
REQ-037 Scenario 3 (PRESCALE=3, en=1 for 9 cycles): count increments exactly 3 times; en dropped for 2 cycles mid-prescale delays the step by 2 cycles.
REQ-038 Scenario 4 (load=1, load_val=13, max_val=9): count becomes 9; simultaneous load and tick: load wins.
REQ-039 Scenario 5 (count=8, max_val lowered to 5, up tick, sat_mode=0): count becomes 0 and wrap pulses.
REQ-040 Scenario 6 (reset asserted between edges with count=7 and prescaler=1): count goes to 0 asynchronously; after release, the first step occurs after PRESCALE enabled cycles.
